// File: rtl/cad_color_pkg.sv
// Shared colour constants: sRGB piecewise-linear knots, 2x2 Bayer rounding offsets,
// clamp/shift constants and the packed 24-bit output pixel type.
package cad_color_pkg;

    localparam int CLAMP_MAX   = 4095;
    localparam int SEG_SHIFT   = 9;
    localparam int RND_DEFAULT = 256;

    // Index 0 is the rightmost element: KNOTS[0] = 0, KNOTS[8] = 255.
    localparam logic [8:0][7:0] KNOTS = {8'd255, 8'd240, 8'd225, 8'd207, 8'd188,
                                         8'd165, 8'd137, 8'd99,  8'd0};

    // Indexed by {y_par, x_cnt[0]}.
    localparam logic [3:0][8:0] BAYER = {9'd192, 9'd448, 9'd320, 9'd64};

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

endpackage

// File: rtl/gamma_pwl_channel.sv
// One colour channel: clamp of the signed linear input (raw_i -> x_o) and, on a separate
// path fed from the pipeline register, piecewise-linear gamma interpolation (x_i -> y_o).
module gamma_pwl_channel
    import cad_color_pkg::*;
#(
    parameter int IN_W = 14
) (
    input  logic signed [IN_W-1:0] raw_i,
    output logic [11:0]             x_o,
    input  logic [11:0]             x_i,
    input  logic [8:0]              rnd_i,
    output logic [7:0]              y_o
);

    logic [3:0]  seg;
    logic [8:0]  off;
    logic [7:0]  k_lo;
    logic [7:0]  k_hi;
    logic [7:0]  diff;
    logic [16:0] prod;
    logic [17:0] sum;
    logic [8:0]  y_full;

    always_comb begin
        if (raw_i[IN_W-1]) begin
            x_o = '0;
        end else if (raw_i > $signed(IN_W'(CLAMP_MAX))) begin
            x_o = 12'(CLAMP_MAX);
        end else begin
            x_o = raw_i[11:0];
        end
    end

    always_comb begin
        seg    = {1'b0, x_i[11:9]};
        off    = x_i[8:0];
        k_lo   = KNOTS[seg];
        k_hi   = KNOTS[seg + 4'd1];
        diff   = k_hi - k_lo;
        prod   = 17'(diff) * 17'(off);
        sum    = 18'(prod) + 18'(rnd_i);
        y_full = 9'(k_lo) + 9'(sum >> SEG_SHIFT);
        y_o    = (y_full > 9'd255) ? 8'hFF : y_full[7:0];
    end

endmodule

// File: rtl/rgb_gamma_encoder.sv
// Linear RGB -> clamped sRGB-gamma 24-bit RGB; latency 2 clk, 1 pixel/clk throughput.
// Backpressure: out_ready low holds the output; stage 1 still fills, then in_ready drops.
// Optional ORDERED_DITHER_EN: 2x2 Bayer rounding from per-pixel (x, line parity) position.
module rgb_gamma_encoder
    import cad_color_pkg::*;
#(
    parameter int IN_W     = 14,
    parameter int H_ACTIVE = 640
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [IN_W-1:0] in_r,
    input  logic signed [IN_W-1:0] in_g,
    input  logic signed [IN_W-1:0] in_b,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   sof,
    output logic [23:0]            out_rgb,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    logic        s1_vld_q, s1_vld_d;
    logic [11:0] s1_r_q, s1_r_d;
    logic [11:0] s1_g_q, s1_g_d;
    logic [11:0] s1_b_q, s1_b_d;
    logic        out_vld_q, out_vld_d;
    rgb24_t      out_rgb_q, out_rgb_d;

    logic [11:0] xr, xg, xb;
    logic [7:0]  yr, yg, yb;
    logic [8:0]  rnd;
    logic        s1_move;
    logic        accept;

    assign s1_move  = s1_vld_q && (!out_vld_q || out_ready);
    assign in_ready = !s1_vld_q || !out_vld_q || out_ready;
    assign accept   = in_valid && in_ready;

    gamma_pwl_channel #(.IN_W(IN_W)) u_ch_r (.raw_i(in_r), .x_o(xr), .x_i(s1_r_q), .rnd_i(rnd), .y_o(yr));
    gamma_pwl_channel #(.IN_W(IN_W)) u_ch_g (.raw_i(in_g), .x_o(xg), .x_i(s1_g_q), .rnd_i(rnd), .y_o(yg));
    gamma_pwl_channel #(.IN_W(IN_W)) u_ch_b (.raw_i(in_b), .x_o(xb), .x_i(s1_b_q), .rnd_i(rnd), .y_o(yb));

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_r_d    = s1_r_q;
        s1_g_d    = s1_g_q;
        s1_b_d    = s1_b_q;
        out_vld_d = out_vld_q;
        out_rgb_d = out_rgb_q;
        // Loading takes priority over draining so accept+drain in one cycle keeps the stage full.
        if (accept) begin
            s1_vld_d = 1'b1;
            s1_r_d   = xr;
            s1_g_d   = xg;
            s1_b_d   = xb;
        end else if (s1_move) begin
            s1_vld_d = 1'b0;
        end
        if (s1_move) begin
            out_vld_d = 1'b1;
            out_rgb_d = {yr, yg, yb};
        end else if (out_ready) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_r_q    <= '0;
            s1_g_q    <= '0;
            s1_b_q    <= '0;
            out_vld_q <= 1'b0;
            out_rgb_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_r_q    <= s1_r_d;
            s1_g_q    <= s1_g_d;
            s1_b_q    <= s1_b_d;
            out_vld_q <= out_vld_d;
            out_rgb_q <= out_rgb_d;
        end
    end

`ifdef ORDERED_DITHER_EN
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

    logic [XW-1:0] x_cnt_q, x_cnt_d;
    logic          y_par_q, y_par_d;
    logic [1:0]    s1_pos_q, s1_pos_d;
    logic [XW-1:0] pos_x;
    logic          pos_y;

    always_comb begin
        pos_x    = sof ? '0 : x_cnt_q;
        pos_y    = sof ? 1'b0 : y_par_q;
        x_cnt_d  = x_cnt_q;
        y_par_d  = y_par_q;
        s1_pos_d = s1_pos_q;
        if (accept) begin
            s1_pos_d = {pos_y, pos_x[0]};
            if (pos_x == XW'(H_ACTIVE - 1)) begin
                x_cnt_d = '0;
                y_par_d = !pos_y;
            end else begin
                x_cnt_d = pos_x + XW'(1);
                y_par_d = pos_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_cnt_q  <= '0;
            y_par_q  <= 1'b0;
            s1_pos_q <= '0;
        end else begin
            x_cnt_q  <= x_cnt_d;
            y_par_q  <= y_par_d;
            s1_pos_q <= s1_pos_d;
        end
    end

    assign rnd = BAYER[s1_pos_q];
`else
    logic unused_cfg;
    assign unused_cfg = &{1'b0, sof, H_ACTIVE[0]};
    assign rnd        = 9'(RND_DEFAULT);
`endif

    assign out_valid = out_vld_q;
    assign out_rgb   = out_rgb_q;
    assign busy      = s1_vld_q || out_vld_q;

endmodule

// File: tb/tb_rgb_gamma_encoder.sv
// Bench for rgb_gamma_encoder: vector table, handshake corner cases, random streaming vs model.
module tb_rgb_gamma_encoder;

    localparam int IN_W     = 14;
    localparam int H_ACTIVE = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic signed [IN_W-1:0] in_r = '0, in_g = '0, in_b = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic                   sof = 1'b0;
    logic [23:0]            out_rgb;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic                   busy;

    always #5 clk = ~clk;

    rgb_gamma_encoder #(.IN_W(IN_W), .H_ACTIVE(H_ACTIVE)) dut (
        .clk(clk), .rst_n(rst_n), .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .in_valid(in_valid), .in_ready(in_ready), .sof(sof), .out_rgb(out_rgb),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model straight from the gamma rules.
    int knots [9] = '{0, 99, 137, 165, 188, 207, 225, 240, 255};
    int bayer [4] = '{64, 320, 448, 192};

    function automatic int enc(input int v, input int rnd);
        int x, seg, off, y;
        x   = (v < 0) ? 0 : ((v > 4095) ? 4095 : v);
        seg = x / 512;
        off = x % 512;
        y   = knots[seg] + ((knots[seg+1] - knots[seg]) * off + rnd) / 512;
        if (y > 255) y = 255;
        return y;
    endfunction

    int bx = 0, by = 0;

    function automatic int take_rnd(input bit s);
        int r;
`ifdef ORDERED_DITHER_EN
        if (s) begin bx = 0; by = 0; end
        r  = bayer[by * 2 + (bx % 2)];
        bx = bx + 1;
        if (bx == H_ACTIVE) begin bx = 0; by = 1 - by; end
`else
        r = 256 + 0 * int'(s);
`endif
        return r;
    endfunction

    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];
    int          acc_cnt = 0;
    int          out_cnt = 0;
    bit          stall_prev = 0;
    logic [23:0] prev_rgb = '0;

    // Monitor: sample handshakes mid-cycle, i.e. the values the next rising edge will act on.
    always @(negedge clk) begin
        int rnd;
        logic [23:0] e;
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 0;
            bx = 0;
            by = 0;
        end else begin
            if (stall_prev) begin
                chk("stall_hold_valid", 32'(out_valid), 1);
                chk("stall_hold_rgb", 32'(out_rgb), 32'(prev_rgb));
            end
            stall_prev = out_valid && !out_ready;
            prev_rgb   = out_rgb;
            if (in_valid && in_ready) begin
                rnd = take_rnd(sof);
                exp_q.push_back({8'(enc(int'(in_r), rnd)), 8'(enc(int'(in_g), rnd)), 8'(enc(int'(in_b), rnd))});
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                chk("out_has_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("stream_data", 32'(out_rgb), 32'(e));
                end
                got_q.push_back(out_rgb);
                out_cnt++;
            end
        end
    end

    typedef struct {
        int          r, g, b;
        logic [23:0] exp;
    } vec_t;

    function automatic int rch();
        return int'($urandom_range(0, 5200)) - 600;
    endfunction

    task automatic set_px(input int r, input int g, input int b);
        in_r = IN_W'(r);
        in_g = IN_W'(g);
        in_b = IN_W'(b);
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        @(posedge clk); #1;
        chk({name, "_in_ready"}, 32'(in_ready), 1);
        set_px(v.r, v.g, v.b);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({name, "_lat1_valid"}, 32'(out_valid), 0);
        @(posedge clk); #1;
        chk({name, "_lat2_valid"}, 32'(out_valid), 1);
        chk({name, "_rgb"}, 32'(out_rgb), 32'(v.exp));
    endtask

    initial begin
        vec_t vt [5];
        vec_t v0;
        int   base, ob, k, cyc;
        int   bp [4][3];
        logic [23:0] dexp [6];

        // Segment-start inputs (offset 0) and saturation cases are independent of the rounding term.
        vt[0] = '{r: 0,     g: 0,    b: 0,    exp: 24'h000000};
        vt[1] = '{r: -8192, g: 8191, b: 512,  exp: 24'h00FF63};
        vt[2] = '{r: 1024,  g: 1536, b: 3584, exp: 24'h89A5F0};
        vt[3] = '{r: 4095,  g: -5,   b: 5000, exp: 24'hFF00FF};
        vt[4] = '{r: 2560,  g: 3072, b: -1,   exp: 24'hCFE100};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_rgb", 32'(out_rgb), 0);
        chk("reset_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(in_ready), 1);

        for (int i = 0; i < 5; i++) apply_vec(vt[i], $sformatf("vec%0d", i));
`ifndef ORDERED_DITHER_EN
        v0 = '{r: 0, g: 256, b: 2048, exp: 24'h0032BC};
        apply_vec(v0, "known_0032bc");
`endif

        // Backpressure: four pixels into a stalled output.
        bp[0] = '{100, 600, 1200};
        bp[1] = '{1800, 2300, 2900};
        bp[2] = '{3300, 3700, 4000};
        bp[3] = '{700, 1300, 2100};
        @(posedge clk); #1;
        base = acc_cnt;
        ob   = out_cnt;
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            k = acc_cnt - base;
            if (k < 4) begin set_px(bp[k][0], bp[k][1], bp[k][2]); in_valid = 1'b1; end
            else in_valid = 1'b0;
            @(posedge clk); #1;
        end
        chk("bp_accepted_two", 32'(acc_cnt - base), 2);
        chk("bp_in_ready_low", 32'(in_ready), 0);
        chk("bp_out_valid", 32'(out_valid), 1);
        chk("bp_nothing_out", 32'(out_cnt - ob), 0);
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            k = acc_cnt - base;
            if (k < 4) begin set_px(bp[k][0], bp[k][1], bp[k][2]); in_valid = 1'b1; end
            else in_valid = 1'b0;
            @(posedge clk); #1;
        end
        chk("bp_all_out", 32'(out_cnt - ob), 4);
        chk("bp_queue_empty", 32'(exp_q.size()), 0);
        chk("bp_busy_idle", 32'(busy), 0);

        // Reset while holding valid output.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_px(rch(), rch(), rch());
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("pre_reset_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_rgb", 32'(out_rgb), 0);
        chk("midrst_busy", 32'(busy), 0);
        out_ready = 1'b1;

        // Full throughput.
        base = acc_cnt;
        ob   = out_cnt;
        for (int c = 0; c < 100; c++) begin
            set_px(rch(), rch(), rch());
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("tp_accepted", 32'(acc_cnt - base), 100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("tp_outputs", 32'(out_cnt - ob), 100);

        // Random valid / ready.
        base = acc_cnt;
        cyc  = 0;
        while ((acc_cnt - base) < 1000 && cyc < 8000) begin
            set_px(rch(), rch(), rch());
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            sof       = ($urandom_range(0, 60) == 0);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        sof       = 1'b0;
        out_ready = 1'b1;
        chk("rand_accepted", 32'(acc_cnt - base), 1000);
        cyc = 0;
        while (busy && cyc < 10) begin @(posedge clk); #1; cyc++; end
        chk("rand_busy_drained", 32'(busy), 0);
        chk("rand_queue_empty", 32'(exp_q.size()), 0);

`ifdef ORDERED_DITHER_EN
        dexp = '{24'h313131, 24'h323232, 24'h313131, 24'h323232, 24'h323232, 24'h313131};
        got_q.delete();
        for (int c = 0; c < 6; c++) begin
            set_px(256, 256, 256);
            sof      = (c == 0);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        sof      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("dither_count", 32'(got_q.size()), 6);
        for (int i = 0; i < 6; i++)
            if (i < got_q.size()) chk($sformatf("dither_px%0d", i), 32'(got_q[i]), 32'(dexp[i]));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgb_gamma_encoder.md
Name: rgb_gamma_encoder

Overview:
Upstream stage of display_driver. Takes linear-light RGB from the chromatic adaptation matrix stage, clamps each channel, applies piecewise-linear sRGB gamma encoding and packs the result to 24-bit RGB. Output drives display_driver input_rgb/input_valid. Elastic 2-stage valid/ready pipeline with backpressure; out_ready is driven by the downstream stage (top level ties it to !display_driver.busy).

Parameters:
IN_W, 14, width of each signed linear input channel (two's complement); valid code range 0..4095.
H_ACTIVE, 640, pixels per line; used only when ORDERED_DITHER_EN is defined.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
in_r  in  IN_W  signed linear red
in_g  in  IN_W  signed linear green
in_b  in  IN_W  signed linear blue
in_valid  in  1  input pixel valid
in_ready  out  1  stage can accept a pixel this cycle
sof  in  1  start-of-frame; qualified with in_valid && in_ready; ignored without the dither macro
out_rgb  out  24  encoded {R[23:16],G[15:8],B[7:0]}
out_valid  out  1  out_rgb valid
out_ready  in  1  downstream accepts
busy  out  1  any pipeline stage holds a pixel

Behaviour:
- Reset on rst_n low at a clk edge. All stage valids 0, out_valid 0, out_rgb 24'h000000, busy 0, dither counters 0. Reset mid-operation drops in-flight pixels silently.
- Per-channel clamp: value < 0 gives 0; value > 4095 gives 4095; otherwise the value is used unchanged, giving a 12-bit x.
- Gamma: seg = x[11:9], off = x[8:0], knots K = {0,99,137,165,188,207,225,240,255}.
- Encoded value: y = K[seg] + (((K[seg+1]-K[seg])*off + RND) >> 9). RND = 256. Result saturates at 255. Products are unsigned 17-bit.
- Stage 1 registers clamped x (seg/off) for all three channels. Stage 2 (output register) registers y.
- Transfer rules:
  - A stage loads when its upstream is valid and the stage is empty or is being drained that cycle.
  - out_valid drops after out_ready && out_valid with no new data arriving.
- in_ready = !s1_valid || (s1 moves to s2). s1 moves when !out_valid || out_ready. This is a combinational ready chain; no skid buffer.
- Latency: a pixel accepted at edge N gives out_valid high after edge N+2 while out_ready stays high. Throughput is 1 pixel/clk.
- Stall: out_ready low holds out_rgb/out_valid stable. s1 still fills if empty, then in_ready goes low. No pixel is lost or duplicated.
- Simultaneous accept and drain in the same cycle is legal at every stage.
- busy = s1_valid || out_valid.
- Order is preserved.

Optional Feature:
ORDERED_DITHER_EN.
- Defined:
  - Pixel counters x_cnt (0..H_ACTIVE-1) and y_par (1 bit) advance on each accepted input.
  - x_cnt wraps at H_ACTIVE-1, and y_par toggles on that wrap.
  - Accepted sof forces that pixel's position to (0,0); counters then continue from there.
  - Position travels with the pixel through stage 1.
  - RND = BAYER[{y_par,x_cnt[0]}], with BAYER = {64,320,448,192}. Output saturates at 255.
- Undefined: no counters, RND = 256, sof unused.

Decomposition:
- Package cad_color_pkg holds:
  - the knot table K (9x8-bit), the BAYER table, and the constants CLAMP_MAX=4095, SEG_SHIFT=9 and RND_DEFAULT=256;
  - a packed rgb24 typedef.
- One natural sub-module, gamma_pwl_channel: a combinational clamp plus interpolation for one channel, instantiated 3x. The pipeline and handshake logic stays in the top.

Test Plan:
1. Reset mid-stream: rst_n low for 1 clk while out_valid is high -> next cycle out_valid=0, out_rgb=000000, busy=0.
2. Known values, out_ready=1: (0,256,2048) -> out_rgb=0032BC exactly 2 clocks after acceptance. (4095,-5,5000) -> FF00FF.
3. Backpressure: stream 4 distinct pixels with out_ready=0 -> in_ready falls after 2 accepted pixels and out_rgb stays stable. Release out_ready -> all 4 pixels appear in order, none duplicated or dropped.
4. Full throughput: 100 back-to-back pixels with out_ready=1 -> 100 outputs on consecutive cycles, matching a reference model.
5. Random out_ready toggling with random in_valid over 1000 pixels -> scoreboard matches and busy=0 after drain.
6. With ORDERED_DITHER_EN and H_ACTIVE=4, input 256 on all channels, sof on the first pixel:
   - RND=64 gives 49 (31h); RND=320 gives 50 (32h); RND=448 gives 50; RND=192 gives 49.
   - Expected per-pixel outputs in acceptance order follow the Bayer pattern: 313131, 323232, 313131, 323232, wrap, then 323232, 313131.
